// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: the counter FSM state type and a width-agnostic
// binary-to-Gray conversion, reused by both the counter and the Gray-to-binary side.
package gray_pkg;

    // Widest code the conversion function handles; callers zero-extend and truncate.
    localparam int unsigned MaxWidth = 64;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Zero-extending a narrower value leaves its Gray code unchanged in the low bits.
    function automatic logic [MaxWidth-1:0] bin_to_gray(input logic [MaxWidth-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter, WIDTH bits wide.
module bin2gray
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = WIDTH'(bin_to_gray(MaxWidth'(i_bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with a valid/ready output handshake, a load port and a
// one-cycle wrap pulse. All outputs are registered.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_wrap_nxt  = 1'b0;

        if (load) begin
            // Load wins over any handshake in the same cycle.
            w_state_nxt = StIdle;
            w_bin_nxt   = load_bin;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (en) begin
                        w_state_nxt = StRun;
                    end
                end
                StRun: begin
                    if (out_ready) begin
                        if (up_dn) begin
                            w_bin_nxt  = r_bin + WIDTH'(1);
                            w_wrap_nxt = (r_bin == '1);
                        end else begin
                            w_bin_nxt  = r_bin - WIDTH'(1);
                            w_wrap_nxt = (r_bin == '0);
                        end
                        w_state_nxt = en ? StRun : StIdle;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    bin2gray #(
        .WIDTH(WIDTH)
    ) u_bin2gray (
        .i_bin (w_bin_nxt),
        .o_gray(w_gray_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_bin   <= '0;
            r_gray  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_gray  <= w_gray_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign out_valid = (r_state == StRun);
    assign gray_out  = r_gray;
    assign bin_out   = r_bin;
    assign wrap      = r_wrap;

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter and code width in bits, minimum 2.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  enable; requests continued code generation.
REQ-005 SHALL have port up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 SHALL have port load  input  1  load strobe for load_bin.
REQ-007 SHALL have port load_bin  input  WIDTH  binary value to load.
REQ-008 SHALL have port out_ready  input  1  consumer ready.
REQ-009 SHALL have port out_valid  output  1  gray_out holds a code offered to the consumer.
REQ-010 SHALL have port gray_out  output  WIDTH  registered Gray code of the current count.
REQ-011 SHALL have port bin_out  output  WIDTH  registered binary current count.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse on modular wrap-around.

Function
REQ-013 SHALL keep gray_out == bin_out ^ (bin_out >> 1) in every cycle; both are registers, with no combinational path from inputs to outputs.
REQ-014 SHALL implement a two-state FSM: IDLE (out_valid=0) and RUN (out_valid=1).
REQ-015 SHALL move from IDLE to RUN on the edge where en=1 and load=0; the count is unchanged, and the current code is presented from the next cycle.
REQ-016 SHALL, in RUN with out_ready=0, hold gray_out, bin_out and out_valid stable, regardless of en or up_dn.
REQ-017 SHALL define a handshake as out_valid=1 and out_ready=1 at a rising edge.
REQ-018 SHALL, on a handshake with load=0, step the count by +1 (up_dn=1) or -1 (up_dn=0) modulo 2^WIDTH; up_dn is sampled in the handshake cycle, and the new code is visible the next cycle.
REQ-019 SHALL, on a handshake, stay in RUN if en=1 and go to IDLE if en=0; the stepped count is held in IDLE and presented on the next RUN entry.
REQ-020 SHALL pulse wrap for exactly one cycle, the cycle after a handshake that steps from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down); wrap=0 otherwise.
REQ-021 SHALL give load highest priority in any state: next cycle bin_out=load_bin, gray_out=its Gray code, state IDLE, out_valid=0, wrap=0.
REQ-022 SHALL ignore a handshake in the same cycle as load: no step and no wrap.
REQ-023 SHALL let any direction change take effect on the next handshake with no idle cycle.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, set state=IDLE, bin_out=0, gray_out=0, out_valid=0, wrap=0, overriding load, en and any handshake.
REQ-025 SHALL treat rst mid-operation identically to reset from power-up, with no residual state.

Structure
REQ-026 SHALL place the state enum (IDLE, RUN) and the bin-to-Gray conversion function in shared package gray_pkg, for reuse by the Gray-to-binary side.
REQ-027 SHALL instantiate one combinational sub-module, bin2gray (parameter WIDTH), that computes the next Gray code from the next binary count before registering it.

Verification (WIDTH=4)
REQ-028 SHALL check: rst, then en=1, up_dn=1, out_ready=1 held -> gray_out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0, with wrap=1 only in the cycle gray_out returns to 0.
REQ-029 SHALL check: in RUN at gray_out=3, out_ready=0 for 5 cycles -> gray_out=3 and out_valid=1 held; out_ready=1 -> next cycle gray_out=2.
REQ-030 SHALL check: after rst, en=1, up_dn=0, one handshake -> bin_out=F, gray_out=8, wrap pulses once.
REQ-031 SHALL check: in RUN, load=1 with load_bin=A and out_ready=1 in the same cycle -> next cycle out_valid=0, bin_out=A, gray_out=F, no step, wrap=0.
REQ-032 SHALL check: handshake with en=0 at bin_out=5 -> IDLE with bin_out=6 held; en=1 -> out_valid=1 with gray_out=5.
REQ-033 SHALL check: rst asserted mid-RUN at bin_out=9 -> next cycle all outputs 0 and state IDLE.
